// File: rtl/single_regfile.sv
// 32-entry register file: two combinational read ports, one debug read port, one write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module single_regfile #(
   parameter int N      = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [N-1:0]      wdata,
   output logic [N-1:0]      rs_data,
   output logic [N-1:0]      rt_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [N-1:0]      dbg_data
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int NPORT = 3;

   logic [N-1:0]      regs_q [DEPTH];
   logic [N-1:0]      regs_d [DEPTH];
   logic              wr_en;
   logic [ADDR_W-1:0] port_addr [NPORT];
   logic [N-1:0]      port_data [NPORT];

   // Address 0 is never written, so entry 0 keeps its reset value of zero forever.
   assign wr_en = !rst && we && (rd_addr != '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[rd_addr] = wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign port_addr[0] = rs_addr;
   assign port_addr[1] = rt_addr;
   assign port_addr[2] = dbg_addr;

   // Reads are forced to zero during reset and for address 0 regardless of storage.
   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         port_data[p] = '0;
         if (!rst && (port_addr[p] != '0)) begin
            port_data[p] = regs_q[port_addr[p]];
         end
`ifdef REGFILE_BYPASS_EN
         if (wr_en && (port_addr[p] == rd_addr)) begin
            port_data[p] = wdata;
         end
`endif
      end
   end

   assign rs_data  = port_data[0];
   assign rt_data  = port_data[1];
   assign dbg_data = port_data[2];

endmodule
